// File: rtl/pe_result_drain_fp8.sv
// Captures one row of BF16 PE results and streams it out as FP8 E4M3 bytes,
// one element per valid/ready beat, with back-to-back row capture on the final accept.
module pe_result_drain_fp8 #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [N*16-1:0]  c_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_sat,
    output logic             out_last
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [N*16-1:0]   bank;
    logic              accept, at_last, capture, advance;
    logic [IDX_W-1:0]  idx_nxt;
    logic [15:0]       enc_in;
    logic [8:0]        enc_out;

    // BF16 -> E4M3 with round-to-nearest-even; returns {sat, fp8}.
    // sat flags any finite magnitude above 448, even when it rounds back down to 448.
    function automatic logic [8:0] enc(input logic [15:0] x);
        logic        s;
        logic [7:0]  e8;
        logic [6:0]  m;
        logic [3:0]  ev;
        logic [6:0]  r;
        logic        rup;
        logic [7:0]  sh;
        logic [15:0] ext;
        logic [3:0]  q;
        s   = x[15];
        e8  = x[14:7];
        m   = x[6:0];
        ev  = '0;
        r   = '0;
        rup = 1'b0;
        sh  = '0;
        ext = '0;
        q   = '0;
        if (e8 == 8'h00) begin
            enc = {1'b0, s, 7'h00};
        end else if (e8 == 8'hFF || e8 > 8'd135 || (e8 == 8'd135 && m > 7'h60)) begin
            enc = {1'b1, s, 7'h7E};
        end else if (e8 >= 8'd121) begin
            // Exponent field is e8-120; low nibble arithmetic suffices for 1..15.
            ev  = e8[3:0] - 4'd8;
            rup = m[3] & ((|m[2:0]) | m[4]);
            r   = {ev, m[6:4]} + {6'd0, rup};
            enc = {1'b0, s, r};
        end else begin
            // Subnormal: ext[15:12] is the value in units of 2^-9, ext[11] guard.
            sh  = 8'd121 - e8;
            ext = {1'b1, m, 8'h00} >> sh;
            rup = ext[11] & ((|ext[10:0]) | ext[12]);
            q   = ext[15:12] + {3'd0, rup};
            enc = {1'b0, s, 3'b000, q};
        end
    endfunction

    always_comb begin
        accept  = out_valid & out_ready;
        at_last = (out_idx == IDX_W'(N - 1));
        capture = load & ((state == IDLE) | (accept & at_last));
        advance = accept & ~at_last;
        idx_nxt = out_idx + 1'b1;
        enc_in  = capture ? c_in[15:0] : bank[int'(idx_nxt)*16 +: 16];
        enc_out = enc(enc_in);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (load) state_nxt = DRAIN;
            DRAIN: if (accept && at_last && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == DRAIN);
        out_valid = (state == DRAIN);
        out_last  = out_valid & at_last;
    end

    always_ff @(posedge clk) begin
        if (capture) bank <= c_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_idx  <= '0;
            out_sat  <= 1'b0;
        end else if (capture) begin
            out_idx  <= '0;
            out_data <= enc_out[7:0];
            out_sat  <= enc_out[8];
        end else if (advance) begin
            out_idx  <= idx_nxt;
            out_data <= enc_out[7:0];
            out_sat  <= enc_out[8];
        end
    end

endmodule
